mux_rr_nx1: RTL

MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

---
 rtl/mux_rr_nx1.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux_rr_nx1.sv
// N-to-1 channel mux with explicit-select or round-robin grant, feeding a
// single registered output slot with valid/ready handshaking on both sides.

module mux_rr_lane #(
  parameter int SW = 2,
  parameter int IDX = 0
) (
  input  logic          gnt_vld,
  input  logic [SW-1:0] gnt_idx,
  input  logic          can_load,
  input  logic          rst,
  output logic          ready
);
  assign ready = !rst && can_load && gnt_vld && (gnt_idx == SW'(IDX));
endmodule

module mux_rr_nx1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] D,
  input  logic [N-1:0]       valid_in,
  output logic [N-1:0]       ready_in,
  input  logic [SW-1:0]      S,
  input  logic               mode,
  output logic [WIDTH-1:0]   Y,
  output logic [SW-1:0]      chan_out,
  output logic               valid_out,
  input  logic               ready_out
);

  logic [N-1:0][WIDTH-1:0] d_arr;
  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [SW-1:0]           chan_q, chan_d;
  logic [SW-1:0]           ptr_q, ptr_d;
  logic                    can_load, gnt_vld, xfer;
  logic [SW-1:0]           gnt_idx;
  int                      idx;

  assign d_arr    = D;
  assign can_load = !valid_q || ready_out;
  assign xfer     = gnt_vld && can_load;

  // Round-robin scans offsets from the far end so the nearest hit past ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (S == SW'(i) && valid_in[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + 1 + k) % N;
        if (valid_in[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(idx);
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_rr_lane #(.SW(SW), .IDX(i)) u_lane (
      .gnt_vld  (gnt_vld),
      .gnt_idx  (gnt_idx),
      .can_load (can_load),
      .rst      (rst),
      .ready    (ready_in[i])
    );
  end

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      y_d     = d_arr[gnt_idx];
      chan_d  = gnt_idx;
      if (mode) ptr_d = gnt_idx;
    end else if (valid_q && ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      chan_q  <= '0;
      ptr_q   <= SW'(N - 1);
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Y         = y_q;
  assign chan_out  = chan_q;
  assign valid_out = valid_q;

endmodule
